// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path:
// datapath widths and the grant-index encoding used by the arbiter.
package rf_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  // The last-grant pointer stores one of these values.
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard.
// A bit is set when a producer of that register issues.
// The bit is cleared when that register's writeback handshakes.
// If both happen on the same edge, the set wins, because a newer
// producer has just issued. Register x0 is never marked busy.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_set_en,
  input  logic [REG_AW-1:0]   i_set_addr,
  input  logic                i_clr_en,
  input  logic [REG_AW-1:0]   i_clr_addr,
  output logic [NUM_REGS-1:0] o_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;

  // Apply the clear first, then the set, so a same-edge set overrides the clear; bit 0 forced low
  always_comb begin
    w_busy_next = r_busy;
    if (i_clr_en) begin
      w_busy_next[i_clr_addr] = 1'b0;
    end
    if (i_set_en && (i_set_addr != '0)) begin
      w_busy_next[i_set_addr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Busy bitmap register, emptied by reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
// Requester A is the fixed-latency pipeline; requester B is the variable-latency unit.
// The winning write is registered once and then drives the RF write port.
// A busy scoreboard tracks destinations whose writeback has not yet handshaked.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_a_valid,
  output logic                o_a_ready,
  input  logic [REG_AW-1:0]   i_a_waddr,
  input  logic [XLEN-1:0]     i_a_wdata,
  input  logic                i_b_valid,
  output logic                o_b_ready,
  input  logic [REG_AW-1:0]   i_b_waddr,
  input  logic [XLEN-1:0]     i_b_wdata,
  input  logic                i_issue_valid,
  input  logic [REG_AW-1:0]   i_issue_rd,
  output logic [NUM_REGS-1:0] o_busy,
  output logic                o_rd_wen,
  output logic [REG_AW-1:0]   o_rd_waddr,
  output logic [XLEN-1:0]     o_rd_wdata
);

  logic              r_last;
  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              w_xfer;
  logic [REG_AW-1:0] w_gnt_addr;
  logic [XLEN-1:0]   w_gnt_data;

  logic              r_rd_wen;
  logic [REG_AW-1:0] r_rd_waddr;
  logic [XLEN-1:0]   r_rd_wdata;

  // Grant selection: a lone requester always wins; under contention use round-robin or A-first
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (!i_rst) begin
      if (i_a_valid && i_b_valid) begin
        if (RR_EN && (r_last == GNT_A)) begin
          w_b_gnt = 1'b1;
        end else begin
          w_a_gnt = 1'b1;
        end
      end else begin
        w_a_gnt = i_a_valid;
        w_b_gnt = i_b_valid;
      end
    end
  end

  assign o_a_ready  = w_a_gnt;
  assign o_b_ready  = w_b_gnt;
  assign w_xfer     = w_a_gnt | w_b_gnt;
  assign w_gnt_addr = w_b_gnt ? i_b_waddr : i_a_waddr;
  assign w_gnt_data = w_b_gnt ? i_b_wdata : i_a_wdata;

  // Last-grant pointer: starts at B so A wins the first contention; it moves only on a transfer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= GNT_B;
    end else if (w_xfer) begin
      r_last <= w_b_gnt ? GNT_B : GNT_A;
    end
  end

  // Output stage: capture the granted write; writes to x0 complete the handshake but never enable the RF
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_wen   <= 1'b0;
      r_rd_waddr <= '0;
      r_rd_wdata <= '0;
    end else if (w_xfer) begin
      r_rd_wen   <= (w_gnt_addr != '0);
      r_rd_waddr <= w_gnt_addr;
      r_rd_wdata <= w_gnt_data;
    end else begin
      r_rd_wen   <= 1'b0;
    end
  end

  assign o_rd_wen   = r_rd_wen;
  assign o_rd_waddr = r_rd_waddr;
  assign o_rd_wdata = r_rd_wdata;

  rf_scoreboard u_scoreboard (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set_en   (i_issue_valid),
    .i_set_addr (i_issue_rd),
    .i_clr_en   (w_xfer),
    .i_clr_addr (w_gnt_addr),
    .o_busy     (o_busy)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter.
// One instance uses round-robin arbitration and a second uses fixed priority.
// Both instances are driven from the same stimulus.
// Inputs change 1 time unit after the rising edge, and outputs are sampled at that same point.
module tb_rf_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_a_valid;
  logic [4:0]  i_a_waddr;
  logic [31:0] i_a_wdata;
  logic        i_b_valid;
  logic [4:0]  i_b_waddr;
  logic [31:0] i_b_wdata;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;

  logic        o_a_ready, o_b_ready, o_rd_wen;
  logic [31:0] o_busy, o_rd_wdata;
  logic [4:0]  o_rd_waddr;

  logic        fp_a_ready, fp_b_ready, fp_rd_wen;
  logic [31:0] fp_busy, fp_rd_wdata;
  logic [4:0]  fp_rd_waddr;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  rf_wb_arbiter #(.RR_EN(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_valid(i_a_valid), .o_a_ready(o_a_ready), .i_a_waddr(i_a_waddr), .i_a_wdata(i_a_wdata),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_waddr(i_b_waddr), .i_b_wdata(i_b_wdata),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd), .o_busy(o_busy),
    .o_rd_wen(o_rd_wen), .o_rd_waddr(o_rd_waddr), .o_rd_wdata(o_rd_wdata)
  );

  rf_wb_arbiter #(.RR_EN(1'b0)) dut_fp (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_valid(i_a_valid), .o_a_ready(fp_a_ready), .i_a_waddr(i_a_waddr), .i_a_wdata(i_a_wdata),
    .i_b_valid(i_b_valid), .o_b_ready(fp_b_ready), .i_b_waddr(i_b_waddr), .i_b_wdata(i_b_wdata),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd), .o_busy(fp_busy),
    .o_rd_wen(fp_rd_wen), .o_rd_waddr(fp_rd_waddr), .o_rd_wdata(fp_rd_wdata)
  );

  // Advance to 1 time unit after the next rising edge
  task tick();
    @(posedge i_clk);
    #1;
  endtask

  task idle_inputs();
    i_a_valid = 1'b0; i_a_waddr = '0; i_a_wdata = '0;
    i_b_valid = 1'b0; i_b_waddr = '0; i_b_wdata = '0;
    i_issue_valid = 1'b0; i_issue_rd = '0;
  endtask

  task pulse_reset();
    idle_inputs();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task test_reset();
    idle_inputs();
    i_rst = 1'b1;
    i_a_valid = 1'b1; i_b_valid = 1'b1;
    tick(); tick();
    vectors++; if (o_rd_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wen got=%0b exp=0", o_rd_wen); end
    vectors++; if (o_busy !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_busy got=%h exp=0", o_busy); end
    vectors++; if (o_rd_waddr !== 5'd0 || o_rd_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_addr_data got=%0d/%h exp=0/0", o_rd_waddr, o_rd_wdata); end
    vectors++; if (o_a_ready !== 1'b0 || o_b_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_readys got=%b%b exp=00", o_a_ready, o_b_ready); end
    vectors++; if (fp_busy !== 32'h0 || fp_rd_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fp got=%h/%b exp=0/0", fp_busy, fp_rd_wen); end
    i_rst = 1'b0;
    i_b_valid = 1'b0;
    #1;
    vectors++; if (o_a_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_a_ready got=%b exp=1", o_a_ready); end
    i_a_valid = 1'b0;
    tick();
  endtask

  task test_single_a();
    i_a_valid = 1'b1; i_a_waddr = 5'd5; i_a_wdata = 32'hDEADBEEF;
    #1;
    vectors++; if (o_a_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL single_a_ready got=%b exp=1", o_a_ready); end
    tick();
    i_a_valid = 1'b0;
    vectors++; if (o_rd_wen !== 1'b1 || o_rd_waddr !== 5'd5 || o_rd_wdata !== 32'hDEADBEEF) begin
      miscompares++; $display("[TB] FAIL single_a_out got=%b/%0d/%h exp=1/5/deadbeef", o_rd_wen, o_rd_waddr, o_rd_wdata); end
    tick();
    vectors++; if (o_rd_wen !== 1'b0 || o_rd_waddr !== 5'd5 || o_rd_wdata !== 32'hDEADBEEF) begin
      miscompares++; $display("[TB] FAIL single_a_hold got=%b/%0d/%h exp=0/5/deadbeef", o_rd_wen, o_rd_waddr, o_rd_wdata); end
  endtask

  task test_round_robin();
    logic exp_a;
    pulse_reset();
    i_a_valid = 1'b1; i_a_waddr = 5'd3; i_a_wdata = 32'h11;
    i_b_valid = 1'b1; i_b_waddr = 5'd4; i_b_wdata = 32'h22;
    for (int k = 0; k < 4; k++) begin
      exp_a = (k % 2 == 0);
      #1;
      vectors++; if (o_a_ready !== exp_a || o_b_ready !== !exp_a) begin
        miscompares++; $display("[TB] FAIL rr_grant[%0d] got a=%b b=%b exp a=%b b=%b", k, o_a_ready, o_b_ready, exp_a, !exp_a); end
      tick();
      vectors++; if (o_rd_wen !== 1'b1 || o_rd_waddr !== (exp_a ? 5'd3 : 5'd4) || o_rd_wdata !== (exp_a ? 32'h11 : 32'h22)) begin
        miscompares++; $display("[TB] FAIL rr_out[%0d] got=%b/%0d/%h exp=1/%0d", k, o_rd_wen, o_rd_waddr, o_rd_wdata, exp_a ? 3 : 4); end
    end
    idle_inputs();
    tick();
  endtask

  task test_fixed_priority();
    pulse_reset();
    i_a_valid = 1'b1; i_a_waddr = 5'd3; i_a_wdata = 32'h11;
    i_b_valid = 1'b1; i_b_waddr = 5'd4; i_b_wdata = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      vectors++; if (fp_a_ready !== 1'b1 || fp_b_ready !== 1'b0) begin
        miscompares++; $display("[TB] FAIL fp_grant[%0d] got a=%b b=%b exp a=1 b=0", k, fp_a_ready, fp_b_ready); end
      tick();
      vectors++; if (fp_rd_wen !== 1'b1 || fp_rd_waddr !== 5'd3 || fp_rd_wdata !== 32'h11) begin
        miscompares++; $display("[TB] FAIL fp_out[%0d] got=%b/%0d/%h exp=1/3/11", k, fp_rd_wen, fp_rd_waddr, fp_rd_wdata); end
    end
    idle_inputs();
    tick();
  endtask

  task test_scoreboard();
    pulse_reset();
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    tick();
    idle_inputs();
    vectors++; if (o_busy !== 32'h80) begin miscompares++; $display("[TB] FAIL sb_set got=%h exp=00000080", o_busy); end
    tick();
    vectors++; if (o_busy !== 32'h80) begin miscompares++; $display("[TB] FAIL sb_hold got=%h exp=00000080", o_busy); end
    i_b_valid = 1'b1; i_b_waddr = 5'd7; i_b_wdata = 32'h77;
    #1;
    vectors++; if (o_b_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL sb_b_ready got=%b exp=1", o_b_ready); end
    tick();
    idle_inputs();
    vectors++; if (o_busy !== 32'h0 || o_rd_wen !== 1'b1 || o_rd_waddr !== 5'd7 || o_rd_wdata !== 32'h77) begin
      miscompares++; $display("[TB] FAIL sb_clear got=%h/%b/%0d/%h exp=0/1/7/77", o_busy, o_rd_wen, o_rd_waddr, o_rd_wdata); end
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    tick();
    // A second issue of rd=7 coincides with B's writeback of the first producer
    i_b_valid = 1'b1; i_b_waddr = 5'd7; i_b_wdata = 32'h78;
    tick();
    idle_inputs();
    vectors++; if (o_busy !== 32'h80 || o_rd_wen !== 1'b1 || o_rd_waddr !== 5'd7) begin
      miscompares++; $display("[TB] FAIL sb_set_wins got=%h/%b/%0d exp=80/1/7", o_busy, o_rd_wen, o_rd_waddr); end
    i_a_valid = 1'b1; i_a_waddr = 5'd7; i_a_wdata = 32'h79;
    tick();
    idle_inputs();
    vectors++; if (o_busy !== 32'h0) begin miscompares++; $display("[TB] FAIL sb_final_clear got=%h exp=0", o_busy); end
  endtask

  task test_back_to_back_x0();
    i_a_valid = 1'b1; i_a_waddr = 5'd10; i_a_wdata = 32'hA;
    tick();
    vectors++; if (o_rd_wen !== 1'b1 || o_rd_waddr !== 5'd10) begin miscompares++; $display("[TB] FAIL b2b_0 got=%b/%0d exp=1/10", o_rd_wen, o_rd_waddr); end
    i_a_waddr = 5'd11; i_a_wdata = 32'hB;
    tick();
    vectors++; if (o_rd_wen !== 1'b1 || o_rd_waddr !== 5'd11 || o_rd_wdata !== 32'hB) begin
      miscompares++; $display("[TB] FAIL b2b_1 got=%b/%0d/%h exp=1/11/b", o_rd_wen, o_rd_waddr, o_rd_wdata); end
    i_a_waddr = 5'd0; i_a_wdata = 32'hFFFFFFFF;
    i_issue_valid = 1'b1; i_issue_rd = 5'd0;
    #1;
    vectors++; if (o_a_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL x0_ready got=%b exp=1", o_a_ready); end
    tick();
    idle_inputs();
    vectors++; if (o_rd_wen !== 1'b0) begin miscompares++; $display("[TB] FAIL x0_wen got=%b exp=0", o_rd_wen); end
    vectors++; if (o_busy !== 32'h0) begin miscompares++; $display("[TB] FAIL x0_busy got=%h exp=0", o_busy); end
  endtask

  task test_reset_mid();
    // Edge N: A writes r13 while r12 issues, leaving the pointer at A
    i_a_valid = 1'b1; i_a_waddr = 5'd13; i_a_wdata = 32'hABC;
    i_issue_valid = 1'b1; i_issue_rd = 5'd12;
    tick();
    idle_inputs();
    vectors++; if (o_rd_wen !== 1'b1 || o_busy !== 32'h1000) begin
      miscompares++; $display("[TB] FAIL mid_pre got=%b/%h exp=1/00001000", o_rd_wen, o_busy); end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    vectors++; if (o_rd_wen !== 1'b0 || o_busy !== 32'h0 || o_rd_waddr !== 5'd0) begin
      miscompares++; $display("[TB] FAIL mid_reset got=%b/%h/%0d exp=0/0/0", o_rd_wen, o_busy, o_rd_waddr); end
    i_a_valid = 1'b1; i_a_waddr = 5'd1; i_a_wdata = 32'h1;
    i_b_valid = 1'b1; i_b_waddr = 5'd2; i_b_wdata = 32'h2;
    #1;
    vectors++; if (o_a_ready !== 1'b1 || o_b_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL mid_ptr got a=%b b=%b exp a=1 b=0", o_a_ready, o_b_ready); end
    tick();
    idle_inputs();
    vectors++; if (o_rd_waddr !== 5'd1) begin miscompares++; $display("[TB] FAIL mid_after got=%0d exp=1", o_rd_waddr); end
  endtask

  initial begin
    idle_inputs();
    i_rst = 1'b1;
    test_reset();
    test_single_a();
    test_round_robin();
    test_fixed_priority();
    test_scoreboard();
    test_back_to_back_x0();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
  - Port A: the fixed-latency ALU/load pipeline.
  - Port B: a variable-latency unit such as mul/div.
- Registers the winning write into a one-stage output that drives the RF write port directly.
- Keeps a per-register busy scoreboard so issue logic can stall on read-after-write hazards against writes still pending.
- Sits between the execute/writeback stages and the register file.

Parameters:
- RR_EN, default 1: 1 = round-robin arbitration between A and B; 0 = fixed priority, A always wins.

Ports:
- i_clk  in  1  global clock
- i_rst  in  1  reset, synchronous, active-high
- i_a_valid  in  1  requester A has a write pending
- o_a_ready  out  1  A's write is accepted this cycle
- i_a_waddr  in  5  A destination register
- i_a_wdata  in  32  A write data
- i_b_valid  in  1  requester B has a write pending
- o_b_ready  out  1  B's write is accepted this cycle
- i_b_waddr  in  5  B destination register
- i_b_wdata  in  32  B write data
- i_issue_valid  in  1  an instruction with a destination register issues this cycle
- i_issue_rd  in  5  destination of the issuing instruction
- o_busy  out  32  per-register pending-write bitmap; bit 0 is always 0
- o_rd_wen  out  1  RF write enable
- o_rd_waddr  out  5  RF write address
- o_rd_wdata  out  32  RF write data

Behaviour:
- Reset values (at the edge where i_rst=1):
  - o_rd_wen=0, o_rd_waddr=0, o_rd_wdata=0, o_busy=0.
  - Last-grant pointer = B, so A wins the first contention.
  - While i_rst=1, o_a_ready=o_b_ready=0.
  - Any in-flight output write is dropped.
- Handshake:
  - A transfer occurs on the edge where valid&ready=1.
  - Requesters hold valid, waddr and wdata stable until ready; valid does not drop before ready.
  - Ready is combinational from the valid inputs and the pointer.
  - At most one ready is high per cycle.
  - The RF never back-pressures, so some requester is granted every cycle any valid is high.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid, RR_EN=1: grant the requester that was not granted last.
  - Both valid, RR_EN=0: grant A.
  - The pointer updates to the granted index on every transfer and holds when idle.
- Output stage latency:
  - A transfer on edge N gives o_rd_wen=1 with the granted addr/data during cycle N+1.
  - No transfer gives o_rd_wen=0; o_rd_waddr and o_rd_wdata hold their last values.
  - Back-to-back transfers give o_rd_wen=1 on consecutive cycles.
- x0 writes: the handshake still completes, so the requester is released, but o_rd_wen stays 0 for that slot.
- Scoreboard:
  - Set: on each edge, busy[i_issue_rd] is set if i_issue_valid and i_issue_rd!=0.
  - Clear: busy[waddr] is cleared on the edge of the transfer for that waddr, at handshake time, not output time.
  - Same register set and cleared on the same edge: set wins, because a newer producer has issued.
  - Issue of a register already busy: the bit stays 1. There is no count, so issue logic never issues a second producer to a busy rd.
  - Transfer to a register that is not busy: legal; the bit stays 0.
  - busy[0] is constant 0.
- Consequence for the RF: the cycle after a handshake, busy is already 0 while the write is still in the output stage. The RF is therefore instantiated with BYPASS_EN=1 when this block is used, so a consumer reading that register in that cycle sees the new data.

Decomposition:
- Shared package rf_pkg:
  - XLEN=32, REG_AW=5, NUM_REGS=32.
  - Grant-index constants GNT_A=0, GNT_B=1.
- One sub-module rf_scoreboard:
  - Inputs: set_en, set_addr, clr_en, clr_addr.
  - Output: the 32-bit busy vector.
  - Implements the set-wins priority and the x0 exclusion.
- Arbiter, pointer and output register stay in the top level.

Test Plan:
- Reset then idle:
  - o_rd_wen=0, o_busy=0, both readys 0 during i_rst.
  - After reset release, a valid on A alone gives o_a_ready=1 in the same cycle.
- Single A write: A valid with waddr=5, wdata=0xDEADBEEF for one cycle.
  - Next cycle o_rd_wen=1, o_rd_waddr=5, o_rd_wdata=0xDEADBEEF.
  - Following cycle o_rd_wen=0.
- Round-robin contention, RR_EN=1: A and B both valid for 4 cycles, A waddr=3/0x11, B waddr=4/0x22.
  - Grants alternate A,B,A,B.
  - o_rd_waddr sequence is 3,4,3,4 on consecutive cycles.
  - Each requester waits at most 1 cycle.
  - Repeat with RR_EN=0: A granted all 4 cycles, B ready stays 0.
- Scoreboard:
  - Issue rd=7 gives o_busy=0x80 next cycle.
  - B transfer to waddr=7 on a later edge gives o_busy=0 the following cycle, with o_rd_wen=1 and o_rd_waddr=7.
  - Issue rd=7 on the same edge as the B transfer to 7: o_busy[7] stays 1.
- x0 write and issue:
  - A valid with waddr=0, wdata=0xFFFFFFFF: o_a_ready=1, then o_rd_wen stays 0.
  - Issue rd=0: o_busy[0] stays 0.
- Reset mid-operation:
  - Transfer on edge N, i_rst=1 on edge N+1: o_rd_wen=0 after that edge.
  - o_busy is cleared; the pointer is back to B, so A wins the next contention.
